instr_fetch_unit: RTL

//  Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the PC,

---
 rtl/rv_fetch_pkg.sv | 13 +
 rtl/fetch_buffer.sv | 56 +++++
 rtl/instr_fetch_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package rv_fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] FETCH_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch buffer: entries are allocated at request accept, filled by
// responses in request order, and popped from the head once filled.
module fetch_buffer
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  input  logic         alloc,
  input  logic [31:0]  alloc_pc,
  input  logic         fill,
  input  logic [31:0]  fill_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         head_ready,
  output logic [AW:0]  count,
  output logic [AW:0]  unfilled
);

  logic [AW:0]  alloc_ptr;
  logic [AW:0]  fill_ptr;
  logic [AW:0]  head_ptr;
  fetch_entry_t entries [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
    end else begin
      if (alloc) alloc_ptr <= alloc_ptr + 1'b1;
      if (fill)  fill_ptr  <= fill_ptr + 1'b1;
      if (pop)   head_ptr  <= head_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      entries[alloc_ptr[AW-1:0]] <= '{pc: alloc_pc, instr: NOP_INSTR, filled: 1'b0};
    end
    if (fill) begin
      entries[fill_ptr[AW-1:0]].instr  <= fill_data;
      entries[fill_ptr[AW-1:0]].filled <= 1'b1;
    end
  end

  assign count      = alloc_ptr - head_ptr;
  assign unfilled   = alloc_ptr - fill_ptr;
  assign head       = entries[head_ptr[AW-1:0]];
  assign head_ready = (count != '0) && head.filled;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word fetches, tracks responses to be
// dropped after a redirect, and presents buffered instructions to IF/ID.
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [31:0]  pc;
  logic [AW:0]  drop_cnt;
  logic [AW:0]  drop_next;
  logic         in_reset_q;
  logic         in_reset;
  logic         accept;
  logic         rsp_live;
  logic         fill;
  logic         pop;
  logic [AW+1:0] inflight_total;

  fetch_entry_t head;
  logic         head_ready;
  logic [AW:0]  count;
  logic [AW:0]  unfilled;

  fetch_buffer #(.DEPTH(FIFO_DEPTH)) u_buf (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (branch_taken),
    .alloc      (accept),
    .alloc_pc   (pc),
    .fill       (fill),
    .fill_data  (imem_rsp_data),
    .pop        (pop),
    .head       (head),
    .head_ready (head_ready),
    .count      (count),
    .unfilled   (unfilled)
  );

  assign in_reset = !resetn || in_reset_q;

  // Requests still owed a response after a redirect share the buffer budget,
  // so buffered plus discarded-in-flight never exceeds FIFO_DEPTH.
  assign inflight_total = (AW+2)'(count) + (AW+2)'(drop_cnt);
  assign imem_req_valid = !in_reset && !branch_taken
                          && (inflight_total < (AW+2)'(FIFO_DEPTH));
  assign imem_addr      = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_live = imem_rsp_valid && (drop_cnt == '0) && (unfilled != '0);
  assign fill     = rsp_live && !branch_taken;

  assign if_valid = head_ready && !branch_taken && !in_reset;
  assign if_instr = if_valid ? head.instr : NOP_INSTR;
  assign if_pc    = if_valid ? head.pc : 32'h0;
  assign pop      = if_valid && !stall;

  // A redirect turns every unfilled entry into a response to discard.
  always_comb begin
    drop_next = drop_cnt;
    if (imem_rsp_valid && (drop_cnt != '0)) drop_next = drop_cnt - 1'b1;
    if (branch_taken) begin
      drop_next = drop_next + unfilled - (rsp_live ? (AW+1)'(1) : (AW+1)'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc         <= RESET_PC;
      drop_cnt   <= '0;
      in_reset_q <= 1'b1;
    end else begin
      in_reset_q <= 1'b0;
      drop_cnt   <= drop_next;
      if (branch_taken) pc <= branch_target & FETCH_ALIGN_MASK;
      else if (accept)  pc <= pc + 32'd4;
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!resetn)
    !(imem_rsp_valid && (drop_cnt == '0) && (unfilled == '0)));

  a_inflight_bound: assert property (@(posedge clk) disable iff (!resetn)
    inflight_total <= (AW+2)'(FIFO_DEPTH));

endmodule
